// File: rtl/npu_agu_pkg.sv
// rtl/npu_agu_pkg.sv - shared AGU state encoding, stride modes, widths and stride helper
package npu_agu_pkg;

  localparam int AGU_AW = 16;
  localparam int AGU_DW = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } agu_state_e;

  // Stride decision after each issued address; shared with the output AGU.
  typedef enum logic [1:0] {
    MODE_LINEAR   = 2'd0,
    MODE_RUN_STEP = 2'd1,
    MODE_RUN_JUMP = 2'd2
  } agu_mode_e;

  function automatic agu_mode_e stride_mode(input logic [7:0] store_len,
                                            input logic [7:0] run_cnt);
    if (store_len == 8'd0) begin
      return MODE_LINEAR;
    end else if (({1'b0, run_cnt} + 9'd1) == {1'b0, store_len}) begin
      return MODE_RUN_JUMP;
    end else begin
      return MODE_RUN_STEP;
    end
  endfunction

endpackage

// File: rtl/agu_sync_fifo.sv
// rtl/agu_sync_fifo.sv - synchronous skid FIFO holding returned IOB words
module agu_sync_fifo #(
  parameter  int DW    = 256,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic [PW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == (PW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  // Head reads as zero when empty so the data output is quiet outside valid words.
  assign o_rdata = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop) begin
        o_count <= o_count + (PW+1)'(1);
      end else if (do_pop && !do_push) begin
        o_count <= o_count - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdata;
  end

  overflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
                               !(i_push && o_full && !i_pop));

endmodule

// File: rtl/iob_read_agu.sv
// rtl/iob_read_agu.sv - IOB read address generator with latency-absorbing skid FIFO
module iob_read_agu
  import npu_agu_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = AGU_DW,
  parameter int AW         = AGU_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_calculate_enable,
  input  logic [7:0]    i_input_layers,
  input  logic [7:0]    i_x_length,
  input  logic [7:0]    i_y_length,
  input  logic [AW-1:0] i_addr_start_r,
  input  logic [7:0]    i_store_length,
  input  logic [7:0]    i_jump_length,
  output logic [AW-1:0] o_iob_raddr,
  output logic          o_iob_rd_en,
  output logic          o_rsel,
  input  logic [DW-1:0] i_iob_rdat,
  output logic [DW-1:0] o_xpe_dat,
  output logic          o_xpe_dat_vld,
  input  logic          i_xpe_ready,
  output logic          o_read_end
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  agu_state_e  state;
  agu_state_e  state_nxt;
  agu_mode_e   mode;

  logic [7:0]    layers_q, x_len_q, y_len_q, store_q, jump_q;
  logic [7:0]    x_cnt, p_cnt, y_cnt, run_cnt;
  logic [AW-1:0] addr_cur;
  logic [RD_LAT-1:0] vld_pipe;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]    inflight;
  logic [7:0]    outstanding;

  logic start, zero_len, issue, credit_ok, drain_done;
  logic x_end, p_end, y_end;

  assign start    = i_calculate_enable && (state == ST_IDLE || state == ST_DONE);
  assign zero_len = (i_input_layers == 8'd0) || (i_x_length == 8'd0) || (i_y_length == 8'd0);

  assign x_end = (x_cnt == x_len_q - 8'd1);
  assign p_end = (p_cnt == layers_q - 8'd1);
  assign y_end = (y_cnt == y_len_q - 8'd1);

  // Reads still owed to the FIFO: the registered strobe plus every pipe stage.
  always_comb begin
    inflight = {7'd0, o_iob_rd_en};
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {7'd0, vld_pipe[i]};
    end
  end

  assign outstanding = 8'(fifo_count) + inflight;
  assign credit_ok   = !fifo_full && (outstanding < 8'(FIFO_DEPTH));

  assign fifo_push     = vld_pipe[RD_LAT-1];
  assign o_xpe_dat_vld = !fifo_empty;
  assign fifo_pop      = o_xpe_dat_vld && i_xpe_ready;
  assign drain_done    = (inflight == 8'd0) &&
                         (fifo_empty || (fifo_count == CW'(1) && fifo_pop));
  assign o_read_end    = (state == ST_DONE);

  assign mode = stride_mode(store_q, run_cnt);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_calculate_enable) state_nxt = zero_len ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        issue = credit_ok;
        if (credit_ok && x_end && p_end && y_end) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_iob_rd_en <= 1'b0;
      o_iob_raddr <= '0;
      o_rsel      <= 1'b0;
      vld_pipe    <= '0;
      layers_q    <= '0;
      x_len_q     <= '0;
      y_len_q     <= '0;
      store_q     <= '0;
      jump_q      <= '0;
      x_cnt       <= '0;
      p_cnt       <= '0;
      y_cnt       <= '0;
      run_cnt     <= '0;
      addr_cur    <= '0;
    end else begin
      state       <= state_nxt;
      o_iob_rd_en <= issue;
      vld_pipe[0] <= o_iob_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end

      if (start) begin
        layers_q <= i_input_layers;
        x_len_q  <= i_x_length;
        y_len_q  <= i_y_length;
        store_q  <= i_store_length;
        jump_q   <= i_jump_length;
        o_rsel   <= i_addr_start_r[12];
        addr_cur <= i_addr_start_r;
        x_cnt    <= '0;
        p_cnt    <= '0;
        y_cnt    <= '0;
        run_cnt  <= '0;
      end else if (issue) begin
        o_iob_raddr <= addr_cur;
        case (mode)
          MODE_LINEAR: begin
            addr_cur <= addr_cur + AW'(1);
          end
          MODE_RUN_JUMP: begin
            addr_cur <= addr_cur + AW'(jump_q);
            run_cnt  <= '0;
          end
          default: begin
            addr_cur <= addr_cur + AW'(1);
            run_cnt  <= run_cnt + 8'd1;
          end
        endcase
        // x innermost, then piece, then row.
        if (!x_end) begin
          x_cnt <= x_cnt + 8'd1;
        end else begin
          x_cnt <= '0;
          if (!p_end) begin
            p_cnt <= p_cnt + 8'd1;
          end else begin
            p_cnt <= '0;
            y_cnt <= y_cnt + 8'd1;
          end
        end
      end
    end
  end

  agu_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_wdata (i_iob_rdat),
    .i_pop   (fifo_pop),
    .o_rdata (o_xpe_dat),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

endmodule

// File: tb/tb_iob_read_agu.sv
// tb/tb_iob_read_agu.sv - self-checking bench for iob_read_agu
module tb_iob_read_agu;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int DW     = 256;
  localparam int AW     = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_calculate_enable = 1'b0;
  logic [7:0]    i_input_layers = '0;
  logic [7:0]    i_x_length = '0;
  logic [7:0]    i_y_length = '0;
  logic [AW-1:0] i_addr_start_r = '0;
  logic [7:0]    i_store_length = '0;
  logic [7:0]    i_jump_length = '0;
  logic [AW-1:0] o_iob_raddr;
  logic          o_iob_rd_en;
  logic          o_rsel;
  logic [DW-1:0] i_iob_rdat = '0;
  logic [DW-1:0] o_xpe_dat;
  logic          o_xpe_dat_vld;
  logic          i_xpe_ready = 1'b1;
  logic          o_read_end;

  iob_read_agu #(.RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_calculate_enable (i_calculate_enable),
    .i_input_layers     (i_input_layers),
    .i_x_length         (i_x_length),
    .i_y_length         (i_y_length),
    .i_addr_start_r     (i_addr_start_r),
    .i_store_length     (i_store_length),
    .i_jump_length      (i_jump_length),
    .o_iob_raddr        (o_iob_raddr),
    .o_iob_rd_en        (o_iob_rd_en),
    .o_rsel             (o_rsel),
    .i_iob_rdat         (i_iob_rdat),
    .o_xpe_dat          (o_xpe_dat),
    .o_xpe_dat_vld      (o_xpe_dat_vld),
    .i_xpe_ready        (i_xpe_ready),
    .o_read_end         (o_read_end)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [DW-1:0] act);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  // Address of the i-th read: whole runs of store words, each run advancing by
  // (store-1)+jump; store==0 is a plain linear walk. Wraps modulo 2^AW.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] sa, input int store,
                                               input int jump, input int i);
    int off;
    if (store == 0) off = i;
    else            off = (i / store) * (store - 1 + jump) + (i % store);
    return sa + AW'(off);
  endfunction

  function automatic logic [DW-1:0] iob_word(input logic [AW-1:0] a);
    return {8{a, ~a ^ 16'h5A3C}};
  endfunction

  // IOB memory model: answers each sampled strobe exactly RD_LAT cycles later.
  logic          s_vld  [RD_LAT+1];
  logic [AW-1:0] s_addr [RD_LAT+1];
  initial for (int j = 0; j <= RD_LAT; j++) begin s_vld[j] = 1'b0; s_addr[j] = '0; end

  always @(negedge i_clk) begin
    for (int j = RD_LAT; j > 0; j--) begin
      s_vld[j]  = s_vld[j-1];
      s_addr[j] = s_addr[j-1];
    end
    s_vld[0]   = o_iob_rd_en;
    s_addr[0]  = o_iob_raddr;
    i_iob_rdat = s_vld[RD_LAT] ? iob_word(s_addr[RD_LAT]) : {(DW/16){16'hDEAD}};
  end

  int cyc = 0;
  int job_cyc = 0;
  int start_cyc = 0;
  int ready_mode = 0;

  initial forever begin
    int k;
    @(posedge i_clk);
    cyc++;
    #1;
    k = cyc - job_cyc;
    if (ready_mode == 0) i_xpe_ready = 1'b1;
    else                 i_xpe_ready = (k >= 10 && k < 20) ? 1'b0 : k[0];
  end

  logic          mon_on = 1'b0;
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_dat  [$];
  int            mon_total = 0, mon_pops = 0, mon_reads = 0;
  bit            final_popped = 0, prev_stall = 0;
  logic [DW-1:0] prev_dat = '0;
  int            first_vld_cyc = -1, first_rd_cyc = -1, last_rd_cyc = -1;

  always @(negedge i_clk) begin
    if (mon_on) begin
      chk("read_end", DW'(o_read_end), DW'((mon_total == 0) || final_popped));
      if (o_iob_rd_en) begin
        if (exp_addr.size() == 0) fail("extra_read", DW'(o_iob_raddr));
        else chk("raddr", DW'(o_iob_raddr), DW'(exp_addr.pop_front()));
        if (mon_reads == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        mon_reads++;
        chk("outstanding_le_depth", DW'((mon_reads - mon_pops) <= DEPTH), DW'(1));
      end
      if (prev_stall) begin
        chk("stall_vld", DW'(o_xpe_dat_vld), DW'(1));
        chk("stall_dat", o_xpe_dat, prev_dat);
      end
      if (o_xpe_dat_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (o_xpe_dat_vld && i_xpe_ready) begin
        if (exp_dat.size() == 0) fail("extra_word", o_xpe_dat);
        else chk("xpe_dat", o_xpe_dat, exp_dat.pop_front());
        mon_pops++;
        if (mon_pops == mon_total) final_popped = 1;
      end
      prev_stall = o_xpe_dat_vld && !i_xpe_ready;
      prev_dat   = o_xpe_dat;
    end
  end

  task automatic start_job(input int x, input int l, input int y, input logic [AW-1:0] sa,
                           input int st, input int jp);
    int tot;
    tot = x * l * y;
    exp_addr.delete();
    exp_dat.delete();
    for (int i = 0; i < tot; i++) begin
      exp_addr.push_back(model_addr(sa, st, jp, i));
      exp_dat.push_back(iob_word(model_addr(sa, st, jp, i)));
    end
    mon_total = tot; mon_pops = 0; mon_reads = 0;
    final_popped = 0; prev_stall = 0;
    first_vld_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
    i_x_length = 8'(x); i_input_layers = 8'(l); i_y_length = 8'(y);
    i_addr_start_r = sa; i_store_length = 8'(st); i_jump_length = 8'(jp);
    i_calculate_enable = 1'b1;
    @(posedge i_clk);
    #1;
    start_cyc = cyc;
    job_cyc = cyc;
    i_calculate_enable = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic wait_job(input string name);
    int n;
    n = 0;
    while (!o_read_end && n < 3000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!o_read_end) fail({name, "_timeout"}, DW'(n));
    @(posedge i_clk);
    #1;
    mon_on = 1'b0;
    chk({name, "_reads_left"}, DW'(exp_addr.size()), DW'(0));
    chk({name, "_words_left"}, DW'(exp_dat.size()), DW'(0));
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_raddr"}, DW'(o_iob_raddr), DW'(0));
    chk({name, "_rd_en"}, DW'(o_iob_rd_en), DW'(0));
    chk({name, "_rsel"}, DW'(o_rsel), DW'(0));
    chk({name, "_dat"}, o_xpe_dat, DW'(0));
    chk({name, "_vld"}, DW'(o_xpe_dat_vld), DW'(0));
    chk({name, "_read_end"}, DW'(o_read_end), DW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk_quiet("reset");
    i_rst = 1'b0;

    chk("model_t2_i3", DW'(model_addr(16'h1000, 3, 8, 3)), DW'(16'h100A));
    chk("model_t2_i5", DW'(model_addr(16'h1000, 3, 8, 5)), DW'(16'h100C));
    chk("model_t2_i6", DW'(model_addr(16'h1000, 3, 8, 6)), DW'(16'h1014));
    chk("model_t4_i2", DW'(model_addr(16'hFFFE, 0, 0, 2)), DW'(16'h0000));

    ready_mode = 0;
    start_job(4, 1, 1, 16'h0100, 0, 0);
    wait_job("t1");
    chk("t1_rsel", DW'(o_rsel), DW'(0));
    chk("t1_first_rd_lat", DW'(first_rd_cyc - start_cyc), DW'(1));
    chk("t1_rd_back_to_back", DW'(last_rd_cyc - first_rd_cyc), DW'(3));
    chk("t1_first_vld_lat", DW'(first_vld_cyc - start_cyc), DW'(RD_LAT + 2));

    start_job(3, 2, 2, 16'h1000, 3, 8);
    wait_job("t2");
    chk("t2_rsel", DW'(o_rsel), DW'(1));
    chk("t2_reads", DW'(mon_reads), DW'(12));

    ready_mode = 1;
    start_job(8, 2, 1, 16'h2000, 5, 3);
    wait_job("t3");
    chk("t3_pops", DW'(mon_pops), DW'(16));
    ready_mode = 0;

    start_job(4, 1, 1, 16'hFFFE, 0, 0);
    wait_job("t4");
    chk("t4_rsel", DW'(o_rsel), DW'(1));

    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    start_job(4, 1, 0, 16'h0400, 0, 0);
    chk("t5_zero_end", DW'(o_read_end), DW'(1));
    repeat (4) @(posedge i_clk);
    #1;
    wait_job("t5");

    start_job(4, 1, 1, 16'h0200, 0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_addr_start_r = 16'h0300;
    i_calculate_enable = 1'b1;
    @(posedge i_clk);
    #1;
    i_calculate_enable = 1'b0;
    wait_job("t5b");

    start_job(8, 2, 2, 16'h0500, 0, 0);
    repeat (3) @(posedge i_clk);
    #1;
    mon_on = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk_quiet("t6_after_rst");
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      #1;
      chk("t6_no_vld", DW'(o_xpe_dat_vld), DW'(0));
      chk("t6_no_rd", DW'(o_iob_rd_en), DW'(0));
    end

    start_job(4, 1, 1, 16'h0100, 0, 0);
    wait_job("t6_rerun");
    chk("t6_rerun_first_vld_lat", DW'(first_vld_cyc - start_cyc), DW'(RD_LAT + 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
